palette_stream_fifo: RTL and testbench
======================================

# palette_stream_fifo

Parametrised single-clock FIFO carrying palette-resolved pixels from pipe stage 5 toward the HDMI output formatter. Valid/ready handshake on both sides, a registered output stage, uses the full storage depth, occupancy and almost-full/almost-empty watermarks, and a synchronous flush for frame restarts. Optional sticky underrun detection flags starvation of the downstream stream.

## Interface
- DATA_W, 24, pixel word width (RGB888)
- ADDR_W, 3, storage address width; storage depth DEPTH = 2^ADDR_W; must be ≥ 1
- AFULL_THRESH, 6, almost_full asserts when count ≥ this
- AEMPTY_THRESH, 1, almost_empty asserts when count ≤ this
- clk_pipe  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all contents
- in_valid  in  1  upstream word present
- in_ready  out  1  FIFO accepts the word this cycle
- in_data  in  DATA_W  upstream word
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  downstream consumes the word this cycle
- out_data  out  DATA_W  registered head word
- count  out  ADDR_W+1  words held (storage + output register), 0..DEPTH+1
- almost_full  out  1  count ≥ AFULL_THRESH
- almost_empty  out  1  count ≤ AEMPTY_THRESH
- underrun  out  1  sticky starvation flag (PALETTE_FIFO_UNDERRUN_EN only)
- underrun_clr  in  1  clears underrun (PALETTE_FIFO_UNDERRUN_EN only)

## Operation
- Capacity DEPTH+1: DEPTH storage entries plus the output register.
- Storage pointers are ADDR_W+1 bits wide (extra wrap bit): empty when pointers are equal; full when the low bits are equal and the wrap bits differ. All DEPTH entries are usable.
- in_ready = !storage_full && !flush. It has no combinational path from out_ready.
- Write: in_valid && in_ready.
- Pop: out_valid && out_ready.
- The output register loads when it is empty or popped this cycle:
  - from the storage head if storage is non-empty;
  - else directly from in_data if a write occurs (bypass);
  - else out_valid clears.
- Order is strictly FIFO; the bypass is used only when storage is empty.
- Simultaneous write and pop with storage full: the pop is taken, the write is refused (in_ready was 0). in_ready rises the next cycle.
- flush: pointers cleared, out_valid ← 0 on the next edge. flush dominates write and pop in the same cycle. Storage array contents are not cleared.
- count, almost_full and almost_empty are combinational from registered state (storage count + out_valid).
- Reset values: out_valid 0, out_data 0, count 0, in_ready 1, almost_full 0, almost_empty 1, underrun 0. Pointers are 0. Storage array is not reset.

## Timing
- Latency into an empty FIFO: word accepted at edge k → out_valid=1 and out_data=word after edge k (one cycle).
- Pop at edge k with storage non-empty → next word in out_data after edge k; back-to-back throughput is 1 word/cycle.
- Ready-to-ready: a pop at edge k from a full FIFO → in_ready=1 after edge k.
- Reset assertion mid-operation clears state immediately, independent of clk_pipe. Deassertion is synchronised externally.

## Configuration
- PALETTE_FIFO_UNDERRUN_EN defined:
  - An arm bit sets on the first pop after reset or flush.
  - While armed, any cycle with out_ready=1 and out_valid=0 sets underrun on the next edge.
  - underrun_clr clears underrun (and wins over a same-cycle set) but does not disarm.
  - flush clears both underrun and the arm bit.
- Undefined: underrun and underrun_clr ports, the arm bit and the flag logic are absent; all other behaviour is identical.

## Structure
- Shared package palette_fifo_pkg holds:
  - PIXEL_W = 24;
  - default ADDR_W;
  - typedef pixel_t (logic [PIXEL_W-1:0]).
- Sub-module palette_fifo_mem: DEPTH×DATA_W register array with one synchronous write port and one asynchronous read port, no reset. Pointer, output-register and flag logic remain in palette_stream_fifo.

## Test plan
- Reset then single write of 0xA1B2C3 with out_ready=0 → out_valid=1 and out_data=0xA1B2C3 one edge later; count=1; almost_empty=1.
- Fill with out_ready=0, writing 0x000001..0x000009 (DEPTH=8) → 9 accepted; in_ready=0 after the 9th write; count=9; almost_full=1 from count=6.
- From full, assert out_ready=1 and in_valid=1 continuously → outputs 0x000001, 0x000002, … in order at 1 word/cycle, no loss or duplication; in_ready returns one cycle after the first pop.
- Random in_valid/out_ready, 10 000 words, pointers wrapping many times → output sequence equals input sequence; count matches the scoreboard every cycle.
- flush with count=5 while in_valid=1 and out_ready=1 → no word accepted or popped that cycle; count=0 and out_valid=0 next edge; next write reaches the output in one cycle.
- With PALETTE_FIFO_UNDERRUN_EN: pop one word, then out_ready=1 with the FIFO empty → underrun=1 next edge and stays set. Pulse underrun_clr → 0. Repeat before any pop after a flush → underrun stays 0.

Source files
------------

// File: rtl/palette_fifo_pkg.sv
// rtl/palette_fifo_pkg.sv - shared pixel types and default sizing for the palette stream FIFO
package palette_fifo_pkg;

    // RGB888 palette-resolved pixel
    localparam int PIXEL_W = 24;

    // Default storage address width (8 storage entries)
    localparam int ADDR_W_DEFAULT = 3;

    typedef logic [PIXEL_W-1:0] pixel_t;

endpackage

// File: rtl/palette_stream_fifo_if.sv
// rtl/palette_stream_fifo_if.sv - upstream and downstream valid/ready pixel streams of the FIFO
interface palette_stream_fifo_if #(
    parameter int DATA_W = palette_fifo_pkg::PIXEL_W
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    // Producer of upstream words and consumer of downstream words
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // The FIFO itself
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/palette_fifo_mem.sv
// rtl/palette_fifo_mem.sv - DEPTH x DATA_W register array, synchronous write, asynchronous read
module palette_fifo_mem #(
    parameter int DATA_W = palette_fifo_pkg::PIXEL_W,
    parameter int ADDR_W = palette_fifo_pkg::ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is never reset; only entries between the pointers are meaningful
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/palette_stream_fifo.sv
// rtl/palette_stream_fifo.sv - pixel FIFO with registered head, watermarks, flush; optional PALETTE_FIFO_UNDERRUN_EN
module palette_stream_fifo
    import palette_fifo_pkg::*;
#(
    parameter int          DATA_W        = PIXEL_W,
    parameter int          ADDR_W        = ADDR_W_DEFAULT,
    parameter int unsigned AFULL_THRESH  = 6,
    parameter int unsigned AEMPTY_THRESH = 1
) (
    input  logic                   clk_pipe,
    input  logic                   reset,
    input  logic                   flush,
    palette_stream_fifo_if.slave   bus,
    output logic [ADDR_W:0]        count,
    output logic                   almost_full,
`ifdef PALETTE_FIFO_UNDERRUN_EN
    output logic                   almost_empty,
    output logic                   underrun,
    input  logic                   underrun_clr
`else
    output logic                   almost_empty
`endif
);

    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   st_count;
    logic              st_empty;
    logic              st_full;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] rd_data;

    logic              in_ready;
    logic              wr;
    logic              pop;
    logic              load;
    logic              from_store;
    logic              bypass;
    logic              st_we;

    // Wrap bit distinguishes full from empty so every storage entry is usable
    assign st_empty = (wr_ptr == rd_ptr);
    assign st_full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                      (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign st_count = wr_ptr - rd_ptr;

    // in_ready depends only on registered state and flush, never on out_ready
    assign in_ready   = !st_full && !flush;
    assign wr         = bus.in_valid && in_ready;
    assign pop        = out_valid_q && bus.out_ready;
    assign load       = !out_valid_q || pop;
    assign from_store = load && !st_empty;
    // An empty storage lets the incoming word go straight into the head register
    assign bypass     = load && st_empty && wr;
    assign st_we      = wr && !bypass;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    assign count        = st_count + (ADDR_W+1)'(out_valid_q);
    assign almost_full  = (32'(count) >= AFULL_THRESH);
    assign almost_empty = (32'(count) <= AEMPTY_THRESH);

    palette_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk_pipe),
        .we    (st_we),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (bus.in_data),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rd_data)
    );

    // Pointers and head register; flush discards everything but leaves the array contents
    always_ff @(posedge clk_pipe or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (st_we) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (from_store) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (load) begin
                out_valid_q <= from_store || bypass;
                if (from_store) begin
                    out_data_q <= rd_data;
                end else if (bypass) begin
                    out_data_q <= bus.in_data;
                end
            end
        end
    end

`ifdef PALETTE_FIFO_UNDERRUN_EN
    logic armed;

    // Starvation is only meaningful once the stream has started; clear wins over set
    always_ff @(posedge clk_pipe or negedge reset) begin
        if (!reset) begin
            armed    <= 1'b0;
            underrun <= 1'b0;
        end else if (flush) begin
            armed    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (pop) begin
                armed <= 1'b1;
            end
            if (underrun_clr) begin
                underrun <= 1'b0;
            end else if (armed && bus.out_ready && !out_valid_q) begin
                underrun <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_palette_stream_fifo.sv
// tb/tb_palette_stream_fifo.sv - randomized and directed bench for palette_stream_fifo against a queue model
module tb_palette_stream_fifo;
    import palette_fifo_pkg::*;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int AFT    = 6;
    localparam int AET    = 1;

    logic            clk   = 1'b0;
    logic            reset = 1'b0;
    logic            flush = 1'b0;
    logic [ADDR_W:0] count;
    logic            almost_full;
    logic            almost_empty;
`ifdef PALETTE_FIFO_UNDERRUN_EN
    logic            underrun;
    logic            underrun_clr = 1'b0;
`endif

    always #5 clk = ~clk;

    palette_stream_fifo_if #(.DATA_W(PIXEL_W)) bus ();

    palette_stream_fifo #(
        .DATA_W        (PIXEL_W),
        .ADDR_W        (ADDR_W),
        .AFULL_THRESH  (AFT),
        .AEMPTY_THRESH (AET)
    ) dut (
        .clk_pipe     (clk),
        .reset        (reset),
        .flush        (flush),
        .bus          (bus.slave),
        .count        (count),
        .almost_full  (almost_full),
`ifdef PALETTE_FIFO_UNDERRUN_EN
        .almost_empty (almost_empty),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
`else
        .almost_empty (almost_empty)
`endif
    );

    int     checks = 0;
    int     errors = 0;
    int     pops   = 0;
    bit     chk_en = 1'b0;
    pixel_t q[$];
    bit     m_armed = 1'b0;
    bit     m_under = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: the FIFO is just a queue of at most DEPTH+1 words
    always @(posedge clk or negedge reset) begin
        int n;
        bit do_pop;
        bit do_push;
        if (!reset) begin
            q.delete();
            m_armed = 1'b0;
            m_under = 1'b0;
        end else if (flush) begin
            q.delete();
            m_armed = 1'b0;
            m_under = 1'b0;
        end else begin
            n       = q.size();
            do_pop  = (n > 0) && bus.out_ready;
            do_push = bus.in_valid && (n < DEPTH + 1);
`ifdef PALETTE_FIFO_UNDERRUN_EN
            if (underrun_clr) m_under = 1'b0;
            else if (m_armed && bus.out_ready && n == 0) m_under = 1'b1;
`endif
            if (do_pop) begin
                m_armed = 1'b1;
                void'(q.pop_front());
                pops++;
            end
            if (do_push) q.push_back(bus.in_data);
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        int n;
        if (chk_en) begin
            n = q.size();
            chk("count", 32'(count), 32'(n));
            chk("out_valid", 32'(bus.out_valid), 32'(n > 0));
            if (n > 0) chk("out_data", 32'(bus.out_data), 32'(q[0]));
            chk("in_ready", 32'(bus.in_ready), 32'(!flush && n < DEPTH + 1));
            chk("almost_full", 32'(almost_full), 32'(n >= AFT));
            chk("almost_empty", 32'(almost_empty), 32'(n <= AET));
`ifdef PALETTE_FIFO_UNDERRUN_EN
            chk("underrun", 32'(underrun), 32'(m_under));
`endif
        end
    end

    initial begin
        int     exp_pop;
        int     nxt;
        int     cyc;
        int     phase;
        bit     accepted;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_almost_full", 32'(almost_full), 0);
        chk("rst_almost_empty", 32'(almost_empty), 1);
`ifdef PALETTE_FIFO_UNDERRUN_EN
        chk("rst_underrun", 32'(underrun), 0);
`endif
        tick();
        reset  = 1'b1;
        chk_en = 1'b1;

        // Single write reaches the head register after one edge
        bus.in_valid = 1'b1;
        bus.in_data  = 24'hA1B2C3;
        tick();
        bus.in_valid = 1'b0;
        chk("single_valid", 32'(bus.out_valid), 1);
        chk("single_data", 32'(bus.out_data), 32'h00A1B2C3);
        chk("single_count", 32'(count), 1);
        chk("single_aempty", 32'(almost_empty), 1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("single_drained", 32'(count), 0);

        // Fill to DEPTH+1 with the consumer stalled
        for (int i = 1; i <= DEPTH + 1; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 24'(i);
            tick();
            chk("fill_count", 32'(count), 32'(i));
            chk("fill_afull", 32'(almost_full), 32'(i >= 6));
        end
        nxt          = DEPTH + 2;
        bus.in_data  = 24'(nxt);
        chk("full_count", 32'(count), 9);
        chk("full_in_ready", 32'(bus.in_ready), 0);
        chk("full_afull", 32'(almost_full), 1);

        // Drain from full with writes continuing: strict order, one word per cycle
        exp_pop       = 1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            chk("stream_valid", 32'(bus.out_valid), 1);
            chk("stream_order", 32'(bus.out_data), 32'(exp_pop));
            exp_pop++;
            accepted = bus.in_ready;
            tick();
            if (k == 0) chk("ready_after_pop", 32'(bus.in_ready), 1);
            if (accepted) begin
                nxt++;
                bus.in_data = 24'(nxt);
            end
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 20 && bus.out_valid; k++) begin
            chk("tail_order", 32'(bus.out_data), 32'(exp_pop));
            exp_pop++;
            tick();
        end
        bus.out_ready = 1'b0;
        chk("tail_last", 32'(exp_pop), 32'(nxt));
        chk("tail_empty", 32'(count), 0);

        // Flush with five words held dominates a same-cycle write and pop
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 24'(16'h0100 + i);
            tick();
        end
        chk("pre_flush_count", 32'(count), 5);
        flush         = 1'b1;
        bus.in_data   = 24'hDEAD00;
        bus.out_ready = 1'b1;
        #1;
        chk("flush_in_ready", 32'(bus.in_ready), 0);
        tick();
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_valid", 32'(bus.out_valid), 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 24'h123456;
        tick();
        bus.in_valid = 1'b0;
        chk("post_flush_valid", 32'(bus.out_valid), 1);
        chk("post_flush_data", 32'(bus.out_data), 32'h00123456);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

`ifdef PALETTE_FIFO_UNDERRUN_EN
        // Starvation before any pop since a flush is not an underrun
        flush = 1'b1;
        tick();
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("unarmed_underrun", 32'(underrun), 0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 24'h0000AA;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("underrun_set", 32'(underrun), 1);
        bus.out_ready = 1'b0;
        tick();
        chk("underrun_sticky", 32'(underrun), 1);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        chk("underrun_cleared", 32'(underrun), 0);
        flush = 1'b1;
        tick();
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("reflushed_underrun", 32'(underrun), 0);
        bus.out_ready = 1'b0;
`endif

        // Random traffic until 10000 words have left the FIFO
        pops = 0;
        cyc  = 0;
        while (pops < 10000 && cyc < 60000) begin
            phase = (cyc / 1500) % 3;
            case (phase)
                0:       begin bus.in_valid = ($urandom_range(0, 3) != 0); bus.out_ready = ($urandom_range(0, 1) != 0); end
                1:       begin bus.in_valid = ($urandom_range(0, 1) != 0); bus.out_ready = ($urandom_range(0, 3) != 0); end
                default: begin bus.in_valid = ($urandom_range(0, 1) != 0); bus.out_ready = ($urandom_range(0, 1) != 0); end
            endcase
            bus.in_data = pixel_t'($urandom);
            flush       = ($urandom_range(0, 999) == 0);
`ifdef PALETTE_FIFO_UNDERRUN_EN
            underrun_clr = ($urandom_range(0, 63) == 0);
`endif
            tick();
            cyc++;
        end
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
`ifdef PALETTE_FIFO_UNDERRUN_EN
        underrun_clr = 1'b0;
`endif
        chk("random_budget", 32'(pops >= 10000), 1);

        // Asynchronous reset in the middle of a cycle clears state at once
        bus.in_valid = 1'b1;
        bus.in_data  = 24'h00BEEF;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 0);
        chk("async_rst_valid", 32'(bus.out_valid), 0);
        tick();
        reset = 1'b1;
        tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
